// File: rtl/arb_grant_ctrl.sv
// arb_grant_ctrl: takes the winner from an upstream fixed-priority arbiter,
// locks ownership for one burst of beats, and ends each burst with a one-cycle
// GAP. The burst ends either when its final beat completes or when the owner
// drops its request, which aborts the burst.
module arb_grant_ctrl #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [2:0]       gnt_id,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             beat_ready,
  output logic [3:0]       gnt,
  output logic [2:0]       owner_id,
  output logic             busy,
  output logic             beat_valid,
  output logic             beat_last,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             xfer_done,
  output logic             xfer_abort
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [2:0] NO_OWNER = 3'd4;

  state_t           r_state, w_state_next;
  logic [2:0]       r_owner, w_owner_next;
  logic [LEN_W-1:0] r_len, w_len_next;
  logic [LEN_W-1:0] r_cnt, w_cnt_next;

  logic w_grant_ok;
  logic w_owner_req;
  logic w_last;
  logic w_accept;
  logic w_done;
  logic w_abort;

  // Qualify the upstream winner and decode beat handshakes from registered state
  always_comb begin
    // gnt_id 4..7 has bit 2 set: "none" or invalid, never a grant
    w_grant_ok  = (gnt_id[2] == 1'b0) && req[gnt_id[1:0]];
    w_owner_req = req[r_owner[1:0]];
    w_last      = (r_state == S_BUSY) && (r_cnt == r_len);
    w_accept    = (r_state == S_BUSY) && beat_ready;
    w_done      = w_accept && w_last;
    // A final beat completing in the same cycle wins over the request drop
    w_abort     = (r_state == S_BUSY) && !w_owner_req && !w_done;
  end

  // Next-state logic: grant capture, beat counting, burst termination
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_len_next   = r_len;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_grant_ok) begin
          w_state_next = S_BUSY;
          w_owner_next = {1'b0, gnt_id[1:0]};
          w_len_next   = burst_len;
          w_cnt_next   = '0;
        end
      end
      S_BUSY: begin
        if (w_done || w_abort) begin
          // Counter returns to 0 in GAP so it never wraps past len_q
          w_state_next = S_GAP;
          w_cnt_next   = '0;
        end else if (w_accept) begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_GAP: begin
        w_state_next = S_IDLE;
        w_owner_next = NO_OWNER;
      end
      default: begin
        w_state_next = S_IDLE;
        w_owner_next = NO_OWNER;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State register with synchronous reset that overrides any burst in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= NO_OWNER;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_len   <= w_len_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Output decode from registered state (done/abort also see this cycle's handshake)
  always_comb begin
    gnt        = (r_state == S_BUSY) ? (4'b0001 << r_owner[1:0]) : 4'b0000;
    owner_id   = r_owner;
    busy       = (r_state != S_IDLE);
    beat_valid = (r_state == S_BUSY);
    beat_last  = w_last;
    beat_cnt   = r_cnt;
    xfer_done  = w_done;
    xfer_abort = w_abort;
  end

endmodule

// File: doc/arb_grant_ctrl.md
ARB_GRANT_CTRL -- requirements
Module: arb_grant_ctrl

Interface
REQ-001 The block SHALL have parameter LEN_W, default 4, width of burst-length field and beat counter.
REQ-002 The block SHALL have ports exactly as follows (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  4  live request lines req[0..3], same signals seen by the upstream arbiter
- gnt_id  in  3  combinational winner from upstream fixed-priority arbiter; 0..3 = requester, 4 = none, 5..7 = invalid
- burst_len  in  LEN_W  beats-minus-one for the burst, sampled at grant
- beat_ready  in  1  downstream accepts current beat
- gnt  out  4  one-hot ownership grant, zero when no owner
- owner_id  out  3  registered owner index, 4 when no owner
- busy  out  1  high in BUSY and GAP
- beat_valid  out  1  beat offered downstream
- beat_last  out  1  current beat is final beat of burst
- beat_cnt  out  LEN_W  index of current beat, 0-based
- xfer_done  out  1  one-cycle pulse, burst completed
- xfer_abort  out  1  one-cycle pulse, burst cut short by owner dropping request

Function
REQ-003 The block SHALL implement states IDLE, BUSY, GAP; all outputs registered or decoded from registered state only.
REQ-004 In IDLE, if gnt_id is 0..3 and req[gnt_id]=1, the block SHALL, next cycle, enter BUSY, load owner_id=gnt_id, capture burst_len into len_q, clear beat_cnt to 0.
REQ-005 In IDLE, gnt_id of 4..7, or gnt_id 0..3 with req[gnt_id]=0, SHALL be ignored (stay IDLE).
REQ-006 gnt SHALL equal one-hot of owner_id in BUSY, 4'b0000 in IDLE and GAP.
REQ-007 beat_valid SHALL be 1 in every BUSY cycle and 0 otherwise; latency from qualifying gnt_id to first beat_valid is exactly 1 cycle.
REQ-008 A beat SHALL be accepted when beat_valid=1 and beat_ready=1; beat_cnt increments by 1 on each non-final accepted beat and holds otherwise.
REQ-009 beat_last SHALL equal beat_valid AND (beat_cnt == len_q); burst length is len_q+1 beats (1..2^LEN_W).
REQ-010 On acceptance of the beat with beat_last=1, the block SHALL pulse xfer_done for that same cycle (decoded) and enter GAP next cycle.
REQ-011 In BUSY, if req[owner_id]=0 and no final beat is accepted that cycle, the block SHALL pulse xfer_abort that cycle and enter GAP next cycle; a non-final beat accepted in the same cycle still counts as transferred.
REQ-012 If req[owner_id] drops in the same cycle the final beat is accepted, the block SHALL treat it as completion: xfer_done=1, xfer_abort=0.
REQ-013 xfer_done and xfer_abort SHALL never be 1 in the same cycle.
REQ-014 GAP SHALL last exactly one cycle (busy=1, gnt=0, beat_valid=0), then IDLE with owner_id=4; new grant evaluated in IDLE, so minimum spacing between bursts is 2 idle-ish cycles (GAP + IDLE).
REQ-015 gnt_id and burst_len changes during BUSY or GAP SHALL have no effect.
REQ-016 beat_cnt SHALL not wrap; with len_q = 2^LEN_W-1 it reaches all-ones on final beat then returns to 0 in GAP.

Reset
REQ-017 rst=1 at a rising edge SHALL, regardless of state (including mid-burst), force next cycle: IDLE, gnt=0, owner_id=4, busy=0, beat_valid=0, beat_last=0, beat_cnt=0, xfer_done=0, xfer_abort=0, len_q=0.
REQ-018 A qualifying gnt_id in the cycle rst is high SHALL be ignored.

Verification
REQ-019 req=4'b0010, gnt_id=1, burst_len=2, beat_ready=1 -> BUSY next cycle, gnt=4'b0010, beats 0,1,2, beat_last and xfer_done on beat 2, GAP, IDLE with owner_id=4.
REQ-020 burst_len=0, beat_ready toggles 0,0,1 -> beat_valid held 3 cycles, beat_last=1 throughout, single xfer_done on third cycle.
REQ-021 owner 3, burst_len=5, req[3] drops after beat 1 accepted -> xfer_abort pulse, gnt=0 next cycle, no xfer_done.
REQ-022 req[0] drops in same cycle as final beat acceptance -> xfer_done=1, xfer_abort=0.
REQ-023 gnt_id=4, then 6, with req=4'b1111 -> stays IDLE, gnt=0; rst asserted mid-burst at beat 1 -> all outputs at REQ-017 values next cycle.
